ysyx_23060236_lsu: RTL and testbench
====================================

# ysyx_23060236_lsu

Load/store stage directly downstream of the execute unit. The execute unit launches one instruction at a time; this block captures it and, for loads and stores, runs one AXI4-Lite transaction. It then returns the writeback triple (rd, wen, data) and pulses `lsu_over`, which re-opens the execute unit's ready. Non-memory instructions pass through with fixed one-cycle latency.

## Interface
Parameters:
- none (32-bit data/address fixed).

Ports:
- `clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `lsu_valid`  in  1  instruction handed over from execute this cycle.
- `lsu_ren` / `lsu_wen`  in  1 / 1  load / store; never both set.
- `val`  in  32  execute result; effective address for load/store, writeback data otherwise.
- `wdata`  in  32  store source (rs2).
- `funct3`  in  3  access size/sign.
- `rd`, `reg_wen`  in  5, 1  destination register and write enable.
- `lsu_over`  out  1  one-cycle completion pulse.
- `wb_rd`, `wb_wen`, `wb_data`  out  5, 1, 32  writeback; valid while `lsu_over`=1.
- `lsu_err`  out  1  with `lsu_over`: misaligned access or non-OKAY response.
- `araddr`  out  32  AXI read address.
- `arvalid`  out  1  AXI read address valid.
- `arready`  in  1  AXI read address ready.
- `arsize`  out  3  AXI read size.
- `rdata`  in  32  AXI read data.
- `rresp`  in  2  AXI read response.
- `rvalid`  in  1  AXI read data valid.
- `rready`  out  1  AXI read data ready.
- `awaddr`  out  32  AXI write address.
- `awvalid`  out  1  AXI write address valid.
- `awready`  in  1  AXI write address ready.
- `awsize`  out  3  AXI write size.
- `wdata_o`  out  32  AXI write data.
- `wstrb`  out  4  AXI write strobes.
- `wvalid`  out  1  AXI write data valid.
- `wready`  in  1  AXI write data ready.
- `bresp`  in  2  AXI write response.
- `bvalid`  in  1  AXI write response valid.
- `bready`  out  1  AXI write response ready.

## Operation

**States:** IDLE, RADDR, RDATA, WRITE, WRESP, DONE.

**IDLE**
- On `lsu_valid`, capture all inputs.
- Misaligned access → DONE with `lsu_err`=1, `wb_wen`=0, no bus activity. Misaligned means a halfword with `val[0]`=1, or a word with `val[1:0]`≠0.
- Else load → RADDR; store → WRITE; other → DONE with `wb_data`=`val`, `wb_wen`=`reg_wen`.

**RADDR**
- `arvalid`=1, `araddr`=`val` (unaligned byte address allowed), `arsize`=`funct3[1:0]`.
- On `arready` → RDATA.

**RDATA**
- `rready`=1.
- On `rvalid`, shift `rdata` right by `val[1:0]`*8, then extract/extend:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Result registered into `wb_data`; `wb_wen`=`reg_wen`; `lsu_err`=(`rresp`≠0) → DONE.
- On error `wb_wen` is forced 0.

**WRITE**
- `awvalid` and `wvalid` both asserted on entry; each drops independently after its own handshake.
- Leave for WRESP once both have completed, including same-cycle completion.
- `wstrb`:
  - SB: 0001 << `val[1:0]`.
  - SH: 0011 << `val[1:0]`.
  - SW: 1111.
- `wdata_o` = `wdata` << (`val[1:0]`*8).
- `awsize` as `arsize`.

**WRESP**
- `bready`=1.
- On `bvalid` → DONE; `lsu_err`=(`bresp`≠0); `wb_wen`=0.

**DONE**
- `lsu_over`=1 for exactly one cycle → IDLE.

**Other rules**
- `lsu_valid` outside IDLE is ignored; the execute unit guarantees it never occurs.
- AXI valids, once raised, stay high until their handshake.
- Address/data/strobes are stable while valid.
- Reset mid-transaction: return to IDLE next edge. All valid/ready outputs drop; the interrupted transaction is not reissued and no `lsu_over` is produced.

## Timing
- Reset values: state IDLE; `lsu_over`, `lsu_err`, `wb_wen`, `arvalid`, `rready`, `awvalid`, `wvalid`, `bready` = 0; `wb_rd`, `wb_data`, `araddr`, `awaddr`, `wdata_o` = 0; `wstrb`, `arsize`, `awsize` = 0.
- Non-memory: accept at cycle T → `lsu_over` at T+1.
- Load with zero-wait slave (ready/valid at first opportunity): `arvalid` at T+1, `rvalid` at T+2, `lsu_over` at T+3.
- Store with zero-wait slave: AW/W at T+1, B at T+2, `lsu_over` at T+3.
- Each slave wait cycle adds one cycle.
- Next `lsu_valid` is accepted earliest in the cycle after `lsu_over`.

## Structure
- Shared defines include gets the state encodings (3-bit localparams) and funct3 load/store codes.
- AXI response OKAY=2'b00 goes in the same include.
- One natural sub-module: `ysyx_23060236_lsu_align`, purely combinational. It produces the store lane shift/strobe and the load extract/extend.

## Test plan
- LW at 0x8000_0004, slave returns 0xDEAD_BEEF with zero wait, `rd`=5 → `lsu_over` 3 cycles after accept; `wb_rd`=5, `wb_wen`=1, `wb_data`=0xDEAD_BEEF.
- LB at 0x...0003, `rdata`=0x80FF_FFFF → `wb_data`=0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- SH at 0x...0002, `wdata`=0x0000_1234 → `wstrb`=1100, `wdata_o`=0x1234_0000, `wb_wen`=0.
- Store with `awready` delayed 3 cycles but `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` holds 4 cycles, then `bready`, exactly one `lsu_over`.
- LW at 0x...0002 → no `arvalid` ever; `lsu_over` at T+1 with `lsu_err`=1, `wb_wen`=0. Load with `rresp`=2'b10 → `lsu_err`=1, `wb_wen`=0.
- ADDI pass-through with `val`=0x42 → `lsu_over` at T+1, `wb_data`=0x42. Reset asserted while in RDATA → `rready` low next cycle and no `lsu_over`.

Source files
------------

// File: rtl/ysyx_23060236_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 access
// codes, AXI response codes and the alignment rule.
package ysyx_23060236_lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WRITE = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // size is funct3[1:0]: 0 byte, 1 half, 2+ word-or-wider.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060236_lsu_if.sv
// AXI4-Lite bus between the load/store unit (master) and memory (slave).
interface ysyx_23060236_lsu_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [2:0]  arsize;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [2:0]  awsize;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, arsize, rready,
        output awaddr, awvalid, awsize, wdata_o, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, arsize, rready,
        input  awaddr, awvalid, awsize, wdata_o, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/ysyx_23060236_lsu_align.sv
// Byte-lane steering: store data/strobe placement and load extract/extend.
module ysyx_23060236_lsu_align
    import ysyx_23060236_lsu_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_strb_o,
    output logic [31:0] st_data_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shift;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        st_data_o = st_data_i << {st_off_i, 3'b000};
        st_strb_o = 4'b1111;
        case (st_funct3_i)
            F3_SB:   st_strb_o = 4'b0001 << st_off_i;
            F3_SH:   st_strb_o = 4'b0011 << st_off_i;
            F3_SW:   st_strb_o = 4'b1111;
            default: st_strb_o = 4'b1111;
        endcase
    end

    always_comb begin
        ld_shift  = ld_raw_i >> {ld_off_i, 3'b000};
        ld_data_o = ld_shift;
        case (ld_funct3_i)
            F3_LB:   ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_LH:   ld_data_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
            F3_LW:   ld_data_o = ld_shift;
            F3_LBU:  ld_data_o = {24'h0, ld_shift[7:0]};
            F3_LHU:  ld_data_o = {16'h0, ld_shift[15:0]};
            default: ld_data_o = ld_shift;
        endcase
    end

endmodule

// File: rtl/ysyx_23060236_lsu.sv
// Load/store stage: captures one instruction from execute, runs at most one
// AXI4-Lite transaction and returns a registered writeback with a done pulse.
module ysyx_23060236_lsu
    import ysyx_23060236_lsu_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     lsu_valid,
    input  logic                     lsu_ren,
    input  logic                     lsu_wen,
    input  logic [31:0]              val,
    input  logic [31:0]              wdata,
    input  logic [2:0]               funct3,
    input  logic [4:0]               rd,
    input  logic                     reg_wen,
    output logic                     lsu_over,
    output logic [4:0]               wb_rd,
    output logic                     wb_wen,
    output logic [31:0]              wb_data,
    output logic                     lsu_err,
    ysyx_23060236_lsu_if.master      axi
);

    lsu_state_e  state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        reg_wen_q;
    logic        lsu_over_q, lsu_err_q, wb_wen_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic [31:0] araddr_q, awaddr_q, wdata_o_q;
    logic [2:0]  arsize_q, awsize_q;
    logic [3:0]  wstrb_q;
    logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;

    logic [3:0]  st_strb_d;
    logic [31:0] st_data_d;
    logic [31:0] ld_data_d;
    logic        rd_err, wr_err, aw_done, w_done;

    // Store lanes come straight from the inputs at accept; loads use captured fields.
    ysyx_23060236_lsu_align u_align (
        .st_funct3_i (funct3),
        .st_off_i    (val[1:0]),
        .st_data_i   (wdata),
        .st_strb_o   (st_strb_d),
        .st_data_o   (st_data_d),
        .ld_funct3_i (funct3_q),
        .ld_off_i    (off_q),
        .ld_raw_i    (axi.rdata),
        .ld_data_o   (ld_data_d)
    );

    assign rd_err  = axi.rresp != RESP_OKAY;
    assign wr_err  = axi.bresp != RESP_OKAY;
    assign aw_done = !awvalid_q || axi.awready;
    assign w_done  = !wvalid_q || axi.wready;

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            funct3_q   <= '0;
            off_q      <= '0;
            reg_wen_q  <= 1'b0;
            lsu_over_q <= 1'b0;
            lsu_err_q  <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            araddr_q   <= '0;
            awaddr_q   <= '0;
            wdata_o_q  <= '0;
            arsize_q   <= '0;
            awsize_q   <= '0;
            wstrb_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
        end else begin
            lsu_over_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (lsu_valid) begin
                        funct3_q  <= funct3;
                        off_q     <= val[1:0];
                        reg_wen_q <= reg_wen;
                        wb_rd_q   <= rd;
                        wb_wen_q  <= 1'b0;
                        lsu_err_q <= 1'b0;
                        if ((lsu_ren || lsu_wen) && is_misaligned(funct3[1:0], val[1:0])) begin
                            lsu_err_q  <= 1'b1;
                            lsu_over_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else if (lsu_ren) begin
                            araddr_q  <= val;
                            arsize_q  <= {1'b0, funct3[1:0]};
                            arvalid_q <= 1'b1;
                            state_q   <= S_RADDR;
                        end else if (lsu_wen) begin
                            awaddr_q  <= val;
                            awsize_q  <= {1'b0, funct3[1:0]};
                            wdata_o_q <= st_data_d;
                            wstrb_q   <= st_strb_d;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WRITE;
                        end else begin
                            wb_data_q  <= val;
                            wb_wen_q   <= reg_wen;
                            lsu_over_q <= 1'b1;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_RADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (axi.rvalid) begin
                        rready_q   <= 1'b0;
                        wb_data_q  <= ld_data_d;
                        wb_wen_q   <= reg_wen_q && !rd_err;
                        lsu_err_q  <= rd_err;
                        lsu_over_q <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_WRITE: begin
                    if (axi.awready) awvalid_q <= 1'b0;
                    if (axi.wready)  wvalid_q  <= 1'b0;
                    // Both channels may finish in the same cycle or in either order.
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (axi.bvalid) begin
                        bready_q   <= 1'b0;
                        wb_wen_q   <= 1'b0;
                        lsu_err_q  <= wr_err;
                        lsu_over_q <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lsu_over    = lsu_over_q;
    assign lsu_err     = lsu_err_q;
    assign wb_rd       = wb_rd_q;
    assign wb_wen      = wb_wen_q;
    assign wb_data     = wb_data_q;
    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.arsize  = arsize_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.awsize  = awsize_q;
    assign axi.wdata_o = wdata_o_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_ysyx_23060236_lsu.sv
// Directed bench for the load/store unit: the bench plays the AXI slave by hand
// and checks every output on the falling edge against hand-computed values.
module tb_ysyx_23060236_lsu;

    logic        clock;
    logic        reset;
    logic        lsu_valid, lsu_ren, lsu_wen, reg_wen;
    logic [31:0] val, wdata;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        lsu_over, wb_wen, lsu_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;

    ysyx_23060236_lsu_if axi ();

    ysyx_23060236_lsu dut (
        .clock     (clock),
        .reset     (reset),
        .lsu_valid (lsu_valid),
        .lsu_ren   (lsu_ren),
        .lsu_wen   (lsu_wen),
        .val       (val),
        .wdata     (wdata),
        .funct3    (funct3),
        .rd        (rd),
        .reg_wen   (reg_wen),
        .lsu_over  (lsu_over),
        .wb_rd     (wb_rd),
        .wb_wen    (wb_wen),
        .wb_data   (wb_data),
        .lsu_err   (lsu_err),
        .axi       (axi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic issue(input logic ren, input logic wen, input logic [31:0] v,
                         input logic [31:0] wd, input logic [2:0] f3, input logic [4:0] rdn);
        lsu_valid = 1'b1;
        lsu_ren   = ren;
        lsu_wen   = wen;
        val       = v;
        wdata     = wd;
        funct3    = f3;
        rd        = rdn;
        reg_wen   = ren || !wen;
        step();
        lsu_valid = 1'b0;
        lsu_ren   = 1'b0;
        lsu_wen   = 1'b0;
    endtask

    // Zero-wait load; wb_data is only meaningful when the response is OKAY.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [4:0] rdn, input logic [31:0] rdv, input logic [1:0] resp,
                            input logic [31:0] exp_data);
        issue(1'b1, 1'b0, addr, 32'h0, f3, rdn);
        check({tag, ".arvalid"}, 32'(axi.arvalid), 32'd1);
        check({tag, ".araddr"}, axi.araddr, addr);
        check({tag, ".arsize"}, 32'(axi.arsize), 32'(f3[1:0]));
        check({tag, ".early_over"}, 32'(lsu_over), 32'd0);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        check({tag, ".arvalid_drop"}, 32'(axi.arvalid), 32'd0);
        check({tag, ".rready"}, 32'(axi.rready), 32'd1);
        axi.rvalid = 1'b1;
        axi.rdata  = rdv;
        axi.rresp  = resp;
        step();
        axi.rvalid = 1'b0;
        axi.rresp  = 2'b00;
        check({tag, ".over"}, 32'(lsu_over), 32'd1);
        check({tag, ".rready_drop"}, 32'(axi.rready), 32'd0);
        check({tag, ".wb_rd"}, 32'(wb_rd), 32'(rdn));
        check({tag, ".wb_wen"}, 32'(wb_wen), (resp == 2'b00) ? 32'd1 : 32'd0);
        check({tag, ".err"}, 32'(lsu_err), (resp == 2'b00) ? 32'd0 : 32'd1);
        if (resp == 2'b00) check({tag, ".wb_data"}, wb_data, exp_data);
        step();
        check({tag, ".over_pulse"}, 32'(lsu_over), 32'd0);
    endtask

    // Zero-wait store with both AW and W accepted in the first cycle.
    task automatic run_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] wd, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wd, input logic [1:0] resp);
        issue(1'b0, 1'b1, addr, wd, f3, 5'd3);
        check({tag, ".awvalid"}, 32'(axi.awvalid), 32'd1);
        check({tag, ".wvalid"}, 32'(axi.wvalid), 32'd1);
        check({tag, ".awaddr"}, axi.awaddr, addr);
        check({tag, ".awsize"}, 32'(axi.awsize), 32'(f3[1:0]));
        check({tag, ".wstrb"}, 32'(axi.wstrb), 32'(exp_strb));
        check({tag, ".wdata_o"}, axi.wdata_o, exp_wd);
        check({tag, ".no_ar"}, 32'(axi.arvalid), 32'd0);
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        step();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        check({tag, ".aw_drop"}, 32'(axi.awvalid), 32'd0);
        check({tag, ".w_drop"}, 32'(axi.wvalid), 32'd0);
        check({tag, ".bready"}, 32'(axi.bready), 32'd1);
        axi.bvalid = 1'b1;
        axi.bresp  = resp;
        step();
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        check({tag, ".over"}, 32'(lsu_over), 32'd1);
        check({tag, ".wb_wen"}, 32'(wb_wen), 32'd0);
        check({tag, ".err"}, 32'(lsu_err), (resp == 2'b00) ? 32'd0 : 32'd1);
        check({tag, ".bready_drop"}, 32'(axi.bready), 32'd0);
        step();
        check({tag, ".over_pulse"}, 32'(lsu_over), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        lsu_valid   = 1'b0;
        lsu_ren     = 1'b0;
        lsu_wen     = 1'b0;
        val         = '0;
        wdata       = '0;
        funct3      = '0;
        rd          = '0;
        reg_wen     = 1'b0;
        axi.arready = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rvalid  = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bvalid  = 1'b0;
        step();
        step();

        // Reset values.
        check("rst.over", 32'(lsu_over), 32'd0);
        check("rst.err", 32'(lsu_err), 32'd0);
        check("rst.wb_wen", 32'(wb_wen), 32'd0);
        check("rst.wb_rd", 32'(wb_rd), 32'd0);
        check("rst.wb_data", wb_data, 32'd0);
        check("rst.arvalid", 32'(axi.arvalid), 32'd0);
        check("rst.rready", 32'(axi.rready), 32'd0);
        check("rst.awvalid", 32'(axi.awvalid), 32'd0);
        check("rst.wvalid", 32'(axi.wvalid), 32'd0);
        check("rst.bready", 32'(axi.bready), 32'd0);
        check("rst.araddr", axi.araddr, 32'd0);
        check("rst.wstrb", 32'(axi.wstrb), 32'd0);
        check("rst.arsize", 32'(axi.arsize), 32'd0);
        reset = 1'b0;
        step();

        // Loads.
        run_load("lw",  32'h8000_0004, 3'b010, 5'd5, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF);
        run_load("lb",  32'h8000_0003, 3'b000, 5'd6, 32'h80FF_FFFF, 2'b00, 32'hFFFF_FF80);
        run_load("lbu", 32'h8000_0003, 3'b100, 5'd6, 32'h80FF_FFFF, 2'b00, 32'h0000_0080);
        run_load("lh",  32'h8000_0002, 3'b001, 5'd9, 32'h8001_1234, 2'b00, 32'hFFFF_8001);
        run_load("lhu", 32'h8000_0002, 3'b101, 5'd9, 32'h8001_1234, 2'b00, 32'h0000_8001);
        run_load("lb1", 32'h8000_0001, 3'b000, 5'd2, 32'h1122_7F44, 2'b00, 32'h0000_007F);
        run_load("lerr", 32'h8000_0008, 3'b010, 5'd4, 32'h1122_3344, 2'b10, 32'h0);

        // Stores.
        run_store("sh", 32'h8000_0002, 3'b001, 32'h0000_1234, 4'b1100, 32'h1234_0000, 2'b00);
        run_store("sb", 32'h8000_0001, 3'b000, 32'h0000_00AB, 4'b0010, 32'h0000_AB00, 2'b00);
        run_store("sw", 32'h8000_0000, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 2'b00);
        run_store("serr", 32'h8000_000C, 3'b010, 32'h0000_0001, 4'b1111, 32'h0000_0001, 2'b11);

        // Store with AW delayed three cycles and W immediate.
        issue(1'b0, 1'b1, 32'h8000_0010, 32'h5555_AAAA, 3'b010, 5'd1);
        check("dly.aw_c1", 32'(axi.awvalid), 32'd1);
        check("dly.w_c1", 32'(axi.wvalid), 32'd1);
        axi.wready = 1'b1;
        step();
        axi.wready = 1'b0;
        check("dly.w_drop", 32'(axi.wvalid), 32'd0);
        check("dly.aw_c2", 32'(axi.awvalid), 32'd1);
        check("dly.no_bready2", 32'(axi.bready), 32'd0);
        step();
        check("dly.aw_c3", 32'(axi.awvalid), 32'd1);
        check("dly.addr_stable", axi.awaddr, 32'h8000_0010);
        step();
        check("dly.aw_c4", 32'(axi.awvalid), 32'd1);
        check("dly.no_over4", 32'(lsu_over), 32'd0);
        axi.awready = 1'b1;
        step();
        axi.awready = 1'b0;
        check("dly.aw_drop", 32'(axi.awvalid), 32'd0);
        check("dly.bready", 32'(axi.bready), 32'd1);
        check("dly.no_over5", 32'(lsu_over), 32'd0);
        axi.bvalid = 1'b1;
        step();
        axi.bvalid = 1'b0;
        check("dly.over", 32'(lsu_over), 32'd1);
        check("dly.err", 32'(lsu_err), 32'd0);
        step();
        check("dly.over_once", 32'(lsu_over), 32'd0);

        // Misaligned accesses finish at T+1 with no bus activity.
        issue(1'b1, 1'b0, 32'h8000_0002, 32'h0, 3'b010, 5'd8);
        check("mis_lw.over", 32'(lsu_over), 32'd1);
        check("mis_lw.err", 32'(lsu_err), 32'd1);
        check("mis_lw.wb_wen", 32'(wb_wen), 32'd0);
        check("mis_lw.arvalid", 32'(axi.arvalid), 32'd0);
        step();
        check("mis_lw.arvalid2", 32'(axi.arvalid), 32'd0);
        check("mis_lw.over_pulse", 32'(lsu_over), 32'd0);
        issue(1'b0, 1'b1, 32'h8000_0003, 32'h1, 3'b001, 5'd8);
        check("mis_sh.over", 32'(lsu_over), 32'd1);
        check("mis_sh.err", 32'(lsu_err), 32'd1);
        check("mis_sh.awvalid", 32'(axi.awvalid), 32'd0);
        check("mis_sh.wvalid", 32'(axi.wvalid), 32'd0);
        step();

        // Non-memory pass-through.
        issue(1'b0, 1'b0, 32'h0000_0042, 32'h0, 3'b000, 5'd7);
        check("addi.over", 32'(lsu_over), 32'd1);
        check("addi.wb_data", wb_data, 32'h0000_0042);
        check("addi.wb_wen", 32'(wb_wen), 32'd1);
        check("addi.wb_rd", 32'(wb_rd), 32'd7);
        check("addi.err", 32'(lsu_err), 32'd0);
        check("addi.no_ar", 32'(axi.arvalid), 32'd0);
        step();
        check("addi.over_pulse", 32'(lsu_over), 32'd0);

        // Reset while waiting for read data.
        issue(1'b1, 1'b0, 32'h8000_0020, 32'h0, 3'b010, 5'd11);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        check("rstmid.rready", 32'(axi.rready), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstmid.rready_drop", 32'(axi.rready), 32'd0);
        check("rstmid.arvalid", 32'(axi.arvalid), 32'd0);
        check("rstmid.no_over", 32'(lsu_over), 32'd0);
        step();
        check("rstmid.no_over2", 32'(lsu_over), 32'd0);
        check("rstmid.rready2", 32'(axi.rready), 32'd0);
        issue(1'b0, 1'b0, 32'h0000_0099, 32'h0, 3'b000, 5'd12);
        check("rstmid.after_over", 32'(lsu_over), 32'd1);
        check("rstmid.after_data", wb_data, 32'h0000_0099);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
